stopwatch_ctrl: RTL and testbench

Control FSM for the stopwatch digit-counter chain. Turns debounced start/stop, clear and lap buttons into a one-cycle count-enable strobe at TICK_HZ and a one-cycle chain-reset pulse. Also drives a display-freeze flag for lap times and halts on full-scale overflow. Sits between the button debouncers and the least-significant digit counter's Enable and every counter's Reset; top level ORs chain_reset with the global Reset.

---
 rtl/stopwatch_pkg.sv | 11 +
 rtl/stopwatch_ctrl_btn_edge.sv | 12 +
 rtl/stopwatch_ctrl.sv | 85 ++++++++
 tb/tb_stopwatch_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding for the stopwatch control FSM
package stopwatch_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVF   = 3'd4
  } state_e;
endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: rising-edge pulse from a debounced level; prev resets high so a held button is not an event
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);
  logic prev_q, prev_d;
  always_comb prev_d = btn;
  always_ff @(posedge clk) prev_q <= rst ? 1'b1 : prev_d;
  assign evt = btn & ~prev_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/pause/lap/clear FSM with tick prescaler and overflow halt
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               start_stop_btn,
  input  logic               clear_btn,
  input  logic               lap_btn,
  input  logic               chain_max,
  output logic               tick_en,
  output logic               chain_reset,
  output logic               freeze,
  output logic               running,
  output logic               overflow,
  output logic [STATE_W-1:0] state
);
  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(PRESCALE);
  logic ev_ss, ev_clr, ev_lap;
  logic act, tc;
  state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic tick_q, tick_d, cr_q, cr_d, frz_q, frz_d, run_q, run_d, ovf_q, ovf_d;
  btn_edge u_ss (.clk(clk), .rst(Reset), .btn(start_stop_btn), .evt(ev_ss));
  btn_edge u_clr (.clk(clk), .rst(Reset), .btn(clear_btn), .evt(ev_clr));
  btn_edge u_lap (.clk(clk), .rst(Reset), .btn(lap_btn), .evt(ev_lap));
  always_comb begin
    act = (state_q == ST_RUN) || (state_q == ST_LAP);
    tc = act && (presc_q == PW'(PRESCALE - 1));
    state_d = state_q;
    cr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cr_d = ev_clr;
        state_d = (!ev_clr && ev_ss) ? ST_RUN : ST_IDLE;
      end
      // full-scale overflow outranks any same-cycle button event
      ST_RUN: state_d = (tc && chain_max) ? ST_OVF : ev_ss ? ST_PAUSE : ev_lap ? ST_LAP : ST_RUN;
      ST_LAP: state_d = (tc && chain_max) ? ST_OVF : ev_ss ? ST_PAUSE : ev_lap ? ST_RUN : ST_LAP;
      ST_PAUSE: begin
        cr_d = ev_clr;
        state_d = ev_clr ? ST_IDLE : ev_ss ? ST_RUN : ST_PAUSE;
      end
      ST_OVF: begin
        cr_d = ev_clr;
        state_d = ev_clr ? ST_IDLE : ST_OVF;
      end
      default: state_d = ST_IDLE;
    endcase
    tick_d = tc && !chain_max;
    presc_d = (state_d == ST_IDLE || tc) ? '0 : act ? presc_q + PW'(1) : presc_q;
    frz_d = state_d == ST_LAP;
    run_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    ovf_d = state_d == ST_OVF;
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      cr_q    <= 1'b0;
      frz_q   <= 1'b0;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      cr_q    <= cr_d;
      frz_q   <= frz_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
    end
  end
  assign tick_en     = tick_q;
  assign chain_reset = cr_q;
  assign freeze      = frz_q;
  assign running     = run_q;
  assign overflow    = ovf_q;
  assign state       = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table with a scoreboard queue, plus tick-cadence measurement
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;
  logic clk = 1'b0;
  logic rst, ss, clr, lap, cmax;
  logic tick_en, chain_reset, freeze, running, overflow;
  logic [STATE_W-1:0] state;
  typedef struct {
    logic r, s, c, l, m;
    state_e st;
    logic t, cr;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] sb[$];
  int gap_sb[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  stopwatch_ctrl #(.CLK_HZ(400), .TICK_HZ(100)) dut (
    .clk(clk), .Reset(rst), .start_stop_btn(ss), .clear_btn(clr), .lap_btn(lap),
    .chain_max(cmax), .tick_en(tick_en), .chain_reset(chain_reset), .freeze(freeze),
    .running(running), .overflow(overflow), .state(state)
  );
  function automatic vec_t v(logic r, s, c, l, m, state_e st, logic t, cr);
    vec_t x;
    x.r = r; x.s = s; x.c = c; x.l = l; x.m = m; x.st = st; x.t = t; x.cr = cr;
    return x;
  endfunction
  task automatic add(input vec_t x, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(x);
  endtask
  task automatic step(input vec_t x, input int idx);
    logic [7:0] exp_v, act_v;
    @(negedge clk);
    rst = x.r; ss = x.s; clr = x.c; lap = x.l; cmax = x.m;
    sb.push_back({x.t, x.cr, x.st == ST_LAP, x.st == ST_RUN || x.st == ST_LAP, x.st == ST_OVF, 3'(x.st)});
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    act_v = {tick_en, chain_reset, freeze, running, overflow, state};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL vec[%0d] {tick,cr,frz,run,ovf,state}: got %b required %b", idx, act_v, exp_v);
    end
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int gap;
    rst = 1'b1; ss = 1'b0; clr = 1'b0; lap = 1'b0; cmax = 1'b0;
    add(v(1,0,0,0,0, ST_IDLE, 0,0), 2);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,1,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 3);
    add(v(0,0,0,0,0, ST_RUN, 1,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 3);
    add(v(0,0,0,0,0, ST_RUN, 1,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,1,0,0,0, ST_PAUSE, 0,0), 1);
    add(v(0,0,0,0,0, ST_PAUSE, 0,0), 5);
    add(v(0,0,0,1,0, ST_PAUSE, 0,0), 1);
    add(v(0,0,0,0,0, ST_PAUSE, 0,0), 4);
    add(v(0,1,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 1,0), 1);
    add(v(0,0,0,1,0, ST_LAP, 0,0), 1);
    add(v(0,0,0,0,0, ST_LAP, 0,0), 2);
    add(v(0,0,0,0,0, ST_LAP, 1,0), 1);
    add(v(0,0,0,1,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,1,0, ST_LAP, 0,0), 1);
    add(v(0,1,0,0,0, ST_PAUSE, 1,0), 1);
    add(v(0,0,0,0,0, ST_PAUSE, 0,0), 1);
    add(v(0,1,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,1,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,1,0,0,0, ST_PAUSE, 0,0), 1);
    add(v(0,0,1,0,0, ST_IDLE, 0,1), 1);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,1,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 3);
    add(v(0,0,0,0,0, ST_RUN, 1,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 3);
    add(v(0,1,0,0,1, ST_OVF, 0,0), 1);
    add(v(0,0,0,0,1, ST_OVF, 0,0), 1);
    add(v(0,1,0,0,1, ST_OVF, 0,0), 1);
    add(v(0,0,1,0,1, ST_IDLE, 0,1), 1);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,1,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,1,0,0,0, ST_PAUSE, 0,0), 1);
    add(v(0,0,0,0,0, ST_PAUSE, 0,0), 1);
    add(v(0,1,1,0,0, ST_IDLE, 0,1), 1);
    add(v(0,1,0,0,0, ST_IDLE, 0,0), 1);
    add(v(1,1,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,1,0,0,0, ST_IDLE, 0,0), 2);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,1,0,0,0, ST_RUN, 0,0), 1);
    add(v(0,0,0,0,0, ST_RUN, 0,0), 3);
    add(v(1,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,0,0,1,0, ST_IDLE, 0,0), 1);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    add(v(0,0,1,0,0, ST_IDLE, 0,1), 1);
    add(v(0,0,0,0,0, ST_IDLE, 0,0), 1);
    foreach (tbl[i]) step(tbl[i], i);
    @(negedge clk);
    ss = 1'b1;
    gap_sb.push_back(5);
    gap_sb.push_back(4);
    gap_sb.push_back(4);
    for (int k = 0; k < 3; k++) begin
      int exp_gap;
      gap = 0;
      do begin
        @(posedge clk);
        #1;
        ss = 1'b0;
        gap++;
      end while (!tick_en && gap < 20);
      exp_gap = gap_sb.pop_front();
      n_cmp++;
      if (gap != exp_gap) begin
        n_bad++;
        $display("FAIL tick_gap[%0d]: got %0d cycles required %0d", k, gap, exp_gap);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
